// File: rtl/velocity_sched.sv
// velocity_sched: round-robin front end for a fixed-latency velocity processor.
// Optional angle wrap into [-pi, pi] when VELSCHED_ANGLE_WRAP_EN is defined.
module velocity_sched #(
  parameter int unsigned LATENCY = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] vel_a,
  input  logic [16:0] ang_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] vel_b,
  input  logic [16:0] ang_b,
  output logic        ack_b,
  output logic [15:0] prcs_velocity,
  output logic [15:0] prcs_angle,
  input  logic [31:0] prcs_result,
  output logic [31:0] res_data,
  output logic        res_id,
  output logic        res_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, NORM, WAIT, DONE} state_t;

  localparam logic [7:0] LAST = 8'(LATENCY - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        ptr;
  logic        own;
  logic        gnt_b;
  logic        any_req;
  logic [15:0] vel_q;

`ifdef VELSCHED_ANGLE_WRAP_EN
  localparam state_t GNT_NEXT = NORM;
  localparam logic signed [16:0] HALF = 17'sd25736;
  localparam logic signed [16:0] FULL = 17'sd51472;

  logic signed [16:0] ang_q;
  logic        [16:0] ang_in;

  assign ang_in     = gnt_b ? ang_b : ang_a;
  assign prcs_angle = ang_q[15:0];
`else
  localparam state_t GNT_NEXT = WAIT;

  logic [15:0] ang_q;
  logic [15:0] ang_in;
  wire         unused_ang = ang_a[16] ^ ang_b[16];

  assign ang_in     = gnt_b ? ang_b[15:0] : ang_a[15:0];
  assign prcs_angle = ang_q;
`endif

  // ptr set means B wins a tie; it always points away from the last winner
  assign any_req       = req_a | req_b;
  assign gnt_b         = req_b & (~req_a | ptr);
  assign prcs_velocity = vel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= 1'b0;
      own       <= 1'b0;
      vel_q     <= '0;
      ang_q     <= '0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            ack_a <= ~gnt_b;
            ack_b <= gnt_b;
            ptr   <= ~gnt_b;
            own   <= gnt_b;
            vel_q <= gnt_b ? vel_b : vel_a;
            ang_q <= ang_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= GNT_NEXT;
          end
        end
`ifdef VELSCHED_ANGLE_WRAP_EN
        NORM: begin
          if (ang_q > HALF) begin
            ang_q <= ang_q - FULL;
          end else if (ang_q < -HALF) begin
            ang_q <= ang_q + FULL;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
`endif
        WAIT: begin
          if (cnt == LAST) begin
            res_data  <= prcs_result;
            res_id    <= own;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
